mem_data_access: RTL and testbench
==================================

# mem_data_access

Memory-stage data-bus master of the MIPS pipeline. Consumes the load/store operation held in the EX/MEM register and runs one SRAM-like request/response transaction per access. Aligns store data, extracts and extends load data, and flags address errors. Raises `data_stall_o` (pipeline `stall_i[3]`) until the access completes.

## Interface
Parameters: none. Op codes are fixed: LB 8'hE0, LH 8'hE1, LW 8'hE3, LBU 8'hE4, LHU 8'hE5, SB 8'hE8, SH 8'hE9, SW 8'hEB; any other `mem_aluop_i` is a non-memory op.

Ports (`name  direction  width  meaning`); clock and reset: one clock; reset is asynchronous and active-high.
- clock_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- exception_i  in  1  pipeline flush; current access is cancelled
- pipe_hold_i  in  1  EX/MEM held by another stall source this cycle
- mem_aluop_i  in  8  op of the instruction in MEM
- mem_addr_i  in  32  byte address (EX/MEM alu data)
- mem_wdata_i  in  32  store source register value
- data_req_o  out  1  bus request
- data_wr_o  out  1  1 = write
- data_size_o  out  2  0 byte, 1 half, 2 word
- data_addr_o  out  32  byte address
- data_wdata_o  out  32  replicated store data
- data_addr_ok_i  in  1  request accepted
- data_data_ok_i  in  1  response / write done
- data_rdata_i  in  32  read word
- data_stall_o  out  1  hold the pipeline
- load_data_o  out  32  extended load result
- adel_o, ades_o  out  1 each  load/store address error
- badvaddr_o  out  32  faulting address

## Operation
- Access valid: memory op and `exception_i` = 0. Misaligned: half-word op with addr[0] = 1, or word op with addr[1:0] ≠ 0.
- Misaligned access:
  - Load op raises `adel_o`; store op raises `ades_o`.
  - `badvaddr_o` = `mem_addr_i`.
  - No request is issued and `data_stall_o` = 0.
- Store data:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata
- Load data: select byte/half by addr[1:0]/addr[1], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- FSM states:
  - IDLE: a valid aligned access drives `data_req_o` combinationally.
    - `addr_ok` → RESP
    - otherwise → REQ
  - REQ: holds `req` and all bus fields constant.
    - `addr_ok` → RESP
    - `exception_i` while in REQ → IDLE, with `req` dropped that cycle.
  - RESP: waits for `data_ok`.
    - `data_ok` with `pipe_hold_i` = 0 → IDLE
    - `data_ok` with `pipe_hold_i` = 1 → DONE; the extended load value is latched.
    - `exception_i` → DRAIN
  - DONE: `load_data_o` comes from the latch and no new request is issued. When `pipe_hold_i` = 0 or `exception_i` = 1 → IDLE.
  - DRAIN: waits for `data_ok` and discards it → IDLE. A new request may not be issued until then.
- `data_stall_o` = 1 whenever a valid aligned access is in progress, except:
  - the `data_ok` cycle in RESP;
  - any cycle in DONE.
- During DRAIN, `data_stall_o` = 1 if a new valid access is present.
- `load_data_o` = extended `data_rdata_i` in the RESP `data_ok` cycle, the latched value in DONE, and 0 otherwise.

## Timing
- Reset values:
  - FSM state: IDLE
  - `data_req_o` 0, `data_wr_o` 0, `data_size_o` 0, `data_addr_o` 0, `data_wdata_o` 0
  - `data_stall_o` 0, `load_data_o` 0, `adel_o` 0, `ades_o` 0, `badvaddr_o` 0
  - Load latch: 0
- Minimum latency: `addr_ok` in the request cycle and `data_ok` the next cycle → 2 cycles (1 stall cycle). EX/MEM advances on the edge ending the `data_ok` cycle.
- `data_ok` in the same cycle as `addr_ok` is not supported; the bus guarantees at least 1 cycle between them.
- Reset mid-transaction: immediate return to IDLE with `req` low. The bus slave is reset together with this block.
- Simultaneous `exception_i` and `data_ok` in RESP: the response is discarded and the FSM goes to IDLE (not DRAIN).
- Only one outstanding transaction at a time.

## Configuration
- `DATA_ADDR_CHECK_EN` defined: alignment checking as above.
- Undefined:
  - `adel_o`, `ades_o` and `badvaddr_o` are tied to 0.
  - Misaligned accesses are issued with addr[1:0] forced to 0 for word ops and addr[0] forced to 0 for half-word ops.

## Test plan
- SW addr 32'h0000_1004, wdata 32'hDEADBEEF, `addr_ok` same cycle, `data_ok` +1 → req high 1 cycle, wr=1, size=2, stall high 1 cycle.
- LB addr 32'h0000_1003, rdata 32'h80FF_0000 → `load_data_o` 32'hFFFF_FF80; LBU at the same address → 32'h0000_0080.
- SH addr 32'h0000_2002, wdata 32'h0000_1234 → `data_wdata_o` 32'h1234_1234, size=1.
- LW addr 32'h0000_0002 → `adel_o`=1, `badvaddr_o`=32'h0000_0002, no req, stall 0. Without the macro: addr 32'h0000_0000 is issued.
- LW with `addr_ok` delayed 3 cycles and `data_ok` arriving while `pipe_hold_i`=1 for 2 cycles → req held constant, data latched, no reissue, value stable until hold drops.
- `exception_i` in RESP, `data_ok` 2 cycles later → DRAIN absorbs it. A new LW is presented during DRAIN: stall stays high, and req is issued only after `data_ok`.

Source files
------------

// File: rtl/mem_data_access.sv
// mem_data_access: memory-stage data-bus master for the MIPS pipeline.
// Runs one request/response bus transaction per load/store in EX/MEM, aligns
// store data, extends load data and stalls the pipeline until completion.
// Optional feature macro: DATA_ADDR_CHECK_EN enables alignment checking
// (adel_o/ades_o/badvaddr_o). When undefined, misaligned addresses are
// silently aligned down and the error outputs are tied to 0.
module mem_data_access (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        exception_i,
  input  logic        pipe_hold_i,
  input  logic [7:0]  mem_aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i,
  output logic        data_stall_o,
  output logic [31:0] load_data_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic [31:0] badvaddr_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 8;

  localparam logic [OP_W-1:0] OP_LB  = 8'hE0;
  localparam logic [OP_W-1:0] OP_LH  = 8'hE1;
  localparam logic [OP_W-1:0] OP_LW  = 8'hE3;
  localparam logic [OP_W-1:0] OP_LBU = 8'hE4;
  localparam logic [OP_W-1:0] OP_LHU = 8'hE5;
  localparam logic [OP_W-1:0] OP_SB  = 8'hE8;
  localparam logic [OP_W-1:0] OP_SH  = 8'hE9;
  localparam logic [OP_W-1:0] OP_SW  = 8'hEB;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  // Request captured at issue so REQ holds it stable and RESP can extend the load
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic              wr;
    logic [1:0]        size;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  state_e            state_q, state_d;
  bus_req_t          req_q, req_d;
  logic [DATA_W-1:0] load_q, load_d;

  logic              is_load, is_store, is_mem;
  logic [1:0]        size;
  logic              misal;
  logic              acc;
  logic [DATA_W-1:0] iss_addr;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] load_ext;

  // Select and extend the addressed byte/half of a read word
  function automatic logic [DATA_W-1:0] extend_load(input logic [OP_W-1:0]   op,
                                                    input logic [1:0]        a,
                                                    input logic [DATA_W-1:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   extend_load = {{24{b[7]}}, b};
      OP_LBU:  extend_load = {24'h0, b};
      OP_LH:   extend_load = {{16{h[15]}}, h};
      OP_LHU:  extend_load = {16'h0, h};
      OP_LW:   extend_load = rd;
      default: extend_load = '0;
    endcase
  endfunction

  // Op decode: direction and access size
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = 2'd0;
    case (mem_aluop_i)
      OP_LB, OP_LBU: begin is_load  = 1'b1; size = 2'd0; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; size = 2'd1; end
      OP_LW:         begin is_load  = 1'b1; size = 2'd2; end
      OP_SB:         begin is_store = 1'b1; size = 2'd0; end
      OP_SH:         begin is_store = 1'b1; size = 2'd1; end
      OP_SW:         begin is_store = 1'b1; size = 2'd2; end
      default:       ;
    endcase
  end

  assign is_mem = is_load | is_store;

`ifdef DATA_ADDR_CHECK_EN
  // Alignment check; misaligned accesses never reach the bus
  always_comb begin
    misal    = ((size == 2'd1) && mem_addr_i[0]) ||
               ((size == 2'd2) && (mem_addr_i[1:0] != 2'b00));
    iss_addr = mem_addr_i;
  end

  // Address-error reporting for misaligned loads/stores
  always_comb begin
    adel_o     = 1'b0;
    ades_o     = 1'b0;
    badvaddr_o = '0;
    if (!reset_i && is_mem && !exception_i && misal) begin
      adel_o     = is_load;
      ades_o     = is_store;
      badvaddr_o = mem_addr_i;
    end
  end
`else
  // No checking: force natural alignment of the issued address
  always_comb begin
    misal = 1'b0;
    case (size)
      2'd1:    iss_addr = {mem_addr_i[31:1], 1'b0};
      2'd2:    iss_addr = {mem_addr_i[31:2], 2'b00};
      default: iss_addr = mem_addr_i;
    endcase
  end

  assign adel_o     = 1'b0;
  assign ades_o     = 1'b0;
  assign badvaddr_o = '0;
`endif

  assign acc = is_mem & ~exception_i & ~misal;

  // Store data replicated across byte lanes
  always_comb begin
    case (size)
      2'd0:    wdata_rep = {4{mem_wdata_i[7:0]}};
      2'd1:    wdata_rep = {2{mem_wdata_i[15:0]}};
      default: wdata_rep = mem_wdata_i;
    endcase
  end

  assign load_ext = extend_load(req_q.op, req_q.addr[1:0], data_rdata_i);

  // Capture request at issue and load value when the pipeline is held
  always_comb begin
    req_d  = req_q;
    load_d = load_q;
    if (state_q == S_IDLE && acc) begin
      req_d.op    = mem_aluop_i;
      req_d.wr    = is_store;
      req_d.size  = size;
      req_d.addr  = iss_addr;
      req_d.wdata = wdata_rep;
    end
    if (state_q == S_RESP && data_data_ok_i && pipe_hold_i && !exception_i) begin
      load_d = load_ext;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      load_q  <= load_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (acc) state_d = data_addr_ok_i ? S_RESP : S_REQ;
      S_REQ: begin
        if (exception_i)         state_d = S_IDLE;
        else if (data_addr_ok_i) state_d = S_RESP;
      end
      S_RESP: begin
        if (data_data_ok_i) begin
          if (exception_i)      state_d = S_IDLE;
          else if (pipe_hold_i) state_d = S_DONE;
          else                  state_d = S_IDLE;
        end else if (exception_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  if (!pipe_hold_i || exception_i) state_d = S_IDLE;
      S_DRAIN: if (data_data_ok_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus, stall and load-result outputs
  always_comb begin
    data_req_o   = 1'b0;
    data_wr_o    = 1'b0;
    data_size_o  = 2'd0;
    data_addr_o  = '0;
    data_wdata_o = '0;
    data_stall_o = 1'b0;
    load_data_o  = '0;
    if (!reset_i) begin
      case (state_q)
        S_IDLE: begin
          if (acc) begin
            data_req_o   = 1'b1;
            data_wr_o    = is_store;
            data_size_o  = size;
            data_addr_o  = iss_addr;
            data_wdata_o = wdata_rep;
            data_stall_o = 1'b1;
          end
        end
        S_REQ: begin
          data_req_o   = ~exception_i;
          data_wr_o    = req_q.wr;
          data_size_o  = req_q.size;
          data_addr_o  = req_q.addr;
          data_wdata_o = req_q.wdata;
          data_stall_o = ~exception_i;
        end
        S_RESP: begin
          data_stall_o = ~data_data_ok_i & ~exception_i;
          if (data_data_ok_i) load_data_o = load_ext;
        end
        S_DONE:  load_data_o  = load_q;
        S_DRAIN: data_stall_o = acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_data_access.sv
// tb_mem_data_access: randomized and directed bench for mem_data_access with a
// transaction-level reference model and a cycle-accurate bus-slave driver.
module tb_mem_data_access;

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_NOP = 8'h00;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        exception_i = 1'b0;
  logic        pipe_hold_i = 1'b0;
  logic [7:0]  mem_aluop_i = OP_NOP;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic        data_addr_ok_i = 1'b0;
  logic        data_data_ok_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic        data_req_o, data_wr_o, data_stall_o, adel_o, ades_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o, data_wdata_o, load_data_o, badvaddr_o;

  int n_checks = 0;
  int n_pass   = 0;

  mem_data_access dut (
    .clock_i(clock_i), .reset_i(reset_i), .exception_i(exception_i),
    .pipe_hold_i(pipe_hold_i), .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .data_req_o(data_req_o), .data_wr_o(data_wr_o),
    .data_size_o(data_size_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i),
    .data_rdata_i(data_rdata_i), .data_stall_o(data_stall_o), .load_data_o(load_data_o),
    .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_is_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic bit m_is_store(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] m_size(input logic [7:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 2'd0;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2'd1;
    return 2'd2;
  endfunction

  function automatic bit m_misaligned(input logic [7:0] op, input logic [31:0] addr);
    logic [31:0] bytes;
    bytes = 32'd1 << m_size(op);
    return (addr % bytes) != 0;
  endfunction

  function automatic logic [31:0] m_issued_addr(input logic [7:0] op, input logic [31:0] addr);
    logic [31:0] bytes;
    bytes = 32'd1 << m_size(op);
    return addr - (addr % bytes);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] w);
    case (m_size(op))
      2'd0:    return (w & 32'hFF) * 32'h0101_0101;
      2'd1:    return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] ea,
                                         input logic [31:0] rd);
    logic [31:0] v;
    logic [31:0] boff;
    boff = ea % 4;
    case (op)
      OP_LB, OP_LBU: begin
        v = (rd >> (8 * boff)) & 32'hFF;
        if (op == OP_LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      OP_LH, OP_LHU: begin
        v = (rd >> (8 * (boff - (boff % 2)))) & 32'hFFFF;
        if (op == OP_LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic bit addr_check_on();
`ifdef DATA_ADDR_CHECK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic idle_cycle(input string tag);
    mem_aluop_i    = OP_NOP;
    exception_i    = 1'b0;
    pipe_hold_i    = 1'b0;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b0;
    data_rdata_i   = $urandom;
    @(negedge clock_i);
    check({tag, "_req"},   32'(data_req_o),   32'd0);
    check({tag, "_stall"}, 32'(data_stall_o), 32'd0);
    check({tag, "_load"},  load_data_o,       32'd0);
    step();
  endtask

  // One access: aok = cycles before addr_ok, dok = cycles from accept to data_ok,
  // hold = cycles pipe_hold_i is high starting with the data_ok cycle
  task automatic do_access(input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int aok, input int dok, input int hold);
    logic [31:0] ea, exp_ld;
    bit          ld;
    ld = m_is_load(op);
    mem_aluop_i    = op;
    mem_addr_i     = addr;
    mem_wdata_i    = wdata;
    exception_i    = 1'b0;
    pipe_hold_i    = 1'b0;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b0;
    data_rdata_i   = $urandom;
    if (addr_check_on() && m_misaligned(op, addr)) begin
      @(negedge clock_i);
      check("mis_adel",  32'(adel_o), 32'(ld));
      check("mis_ades",  32'(ades_o), 32'(!ld));
      check("mis_bva",   badvaddr_o,  addr);
      check("mis_req",   32'(data_req_o),   32'd0);
      check("mis_stall", 32'(data_stall_o), 32'd0);
      step();
      return;
    end
    ea     = m_issued_addr(op, addr);
    exp_ld = m_load(op, ea, rdata);
    for (int k = 0; k <= aok; k++) begin
      data_addr_ok_i = (k == aok);
      @(negedge clock_i);
      check("req",   32'(data_req_o),   32'd1);
      check("wr",    32'(data_wr_o),    32'(m_is_store(op)));
      check("size",  32'(data_size_o),  32'(m_size(op)));
      check("addr",  data_addr_o,       ea);
      if (!ld) check("wdata", data_wdata_o, m_wdata(op, wdata));
      check("stall", 32'(data_stall_o), 32'd1);
      check("err",   32'({adel_o, ades_o}), 32'd0);
      step();
    end
    data_addr_ok_i = 1'b0;
    for (int k = 1; k <= dok; k++) begin
      data_data_ok_i = (k == dok);
      pipe_hold_i    = (k == dok) && (hold > 0);
      data_rdata_i   = (k == dok) ? rdata : $urandom;
      @(negedge clock_i);
      check("resp_req",   32'(data_req_o),   32'd0);
      check("resp_stall", 32'(data_stall_o), (k == dok) ? 32'd0 : 32'd1);
      if (k == dok && ld) check("load", load_data_o, exp_ld);
      step();
    end
    data_data_ok_i = 1'b0;
    for (int j = 1; j <= hold; j++) begin
      pipe_hold_i  = (j < hold);
      data_rdata_i = $urandom;
      @(negedge clock_i);
      check("done_req",   32'(data_req_o),   32'd0);
      check("done_stall", 32'(data_stall_o), 32'd0);
      if (ld) check("done_load", load_data_o, exp_ld);
      step();
    end
    pipe_hold_i = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0]  ops [8];
    logic [7:0]  op;
    logic [31:0] a;
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

    // Reset state with a misaligned store presented
    reset_i     = 1'b1;
    mem_aluop_i = OP_SW;
    mem_addr_i  = 32'h0000_0006;
    mem_wdata_i = 32'hCAFE_F00D;
    @(negedge clock_i);
    check("rst_req",   32'(data_req_o),   32'd0);
    check("rst_wr",    32'(data_wr_o),    32'd0);
    check("rst_size",  32'(data_size_o),  32'd0);
    check("rst_addr",  data_addr_o,       32'd0);
    check("rst_wdata", data_wdata_o,      32'd0);
    check("rst_stall", 32'(data_stall_o), 32'd0);
    check("rst_load",  load_data_o,       32'd0);
    check("rst_err",   32'({adel_o, ades_o}), 32'd0);
    check("rst_bva",   badvaddr_o,        32'd0);
    step();
    reset_i = 1'b0;
    idle_cycle("idle0");

    // Directed cases from the plan
    do_access(OP_SW,  32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 1, 0);
    do_access(OP_LB,  32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 1, 0);
    do_access(OP_LBU, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 1, 0);
    do_access(OP_SH,  32'h0000_2002, 32'h0000_1234, 32'h0, 0, 1, 0);
    do_access(OP_LW,  32'h0000_0002, 32'h0, 32'h1357_9BDF, 0, 1, 0);
    idle_cycle("idle1");
    do_access(OP_LW,  32'h0000_3000, 32'h0, 32'hA5A5_1234, 3, 1, 2);
    do_access(OP_LH,  32'h0000_3002, 32'h0, 32'hF00F_1234, 1, 2, 3);

    // Exception in RESP: DRAIN absorbs the late data_ok, new LW waits
    mem_aluop_i = OP_LW; mem_addr_i = 32'h0000_0010;
    data_addr_ok_i = 1'b1;
    @(negedge clock_i);
    check("ex_req", 32'(data_req_o), 32'd1);
    step();
    data_addr_ok_i = 1'b0;
    exception_i    = 1'b1;
    @(negedge clock_i);
    check("ex_resp_stall", 32'(data_stall_o), 32'd0);
    check("ex_resp_req",   32'(data_req_o),   32'd0);
    step();
    exception_i = 1'b0;
    mem_aluop_i = OP_LW; mem_addr_i = 32'h0000_0020;
    @(negedge clock_i);
    check("drain_req",   32'(data_req_o),   32'd0);
    check("drain_stall", 32'(data_stall_o), 32'd1);
    step();
    data_data_ok_i = 1'b1;
    @(negedge clock_i);
    check("drain_ok_req",   32'(data_req_o),   32'd0);
    check("drain_ok_stall", 32'(data_stall_o), 32'd1);
    check("drain_ok_load",  load_data_o,       32'd0);
    step();
    do_access(OP_LW, 32'h0000_0020, 32'h0, 32'h2468_ACE0, 0, 1, 0);

    // Exception in REQ drops req immediately
    mem_aluop_i = OP_LHU; mem_addr_i = 32'h0000_0042;
    @(negedge clock_i);
    check("exreq_req0", 32'(data_req_o), 32'd1);
    step();
    exception_i = 1'b1;
    @(negedge clock_i);
    check("exreq_req1",  32'(data_req_o),   32'd0);
    check("exreq_stall", 32'(data_stall_o), 32'd0);
    step();
    do_access(OP_LHU, 32'h0000_0046, 32'h0, 32'h8765_4321, 0, 1, 0);

    // Exception together with data_ok in RESP: straight back to IDLE
    mem_aluop_i = OP_LW; mem_addr_i = 32'h0000_0030;
    data_addr_ok_i = 1'b1;
    @(negedge clock_i);
    step();
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b1;
    exception_i    = 1'b1;
    @(negedge clock_i);
    check("exok_stall", 32'(data_stall_o), 32'd0);
    step();
    data_data_ok_i = 1'b0;
    do_access(OP_SB, 32'h0000_0035, 32'h0000_00C3, 32'h0, 0, 2, 0);

    // Exception while in DONE releases it
    do_access(OP_LB, 32'h0000_0051, 32'h0, 32'h0000_7F00, 0, 1, 0);
    mem_aluop_i = OP_LB; mem_addr_i = 32'h0000_0052;
    data_addr_ok_i = 1'b1;
    @(negedge clock_i);
    step();
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b1; pipe_hold_i = 1'b1; data_rdata_i = 32'h00FE_0000;
    @(negedge clock_i);
    check("exdone_ok_load", load_data_o, 32'hFFFF_FFFE);
    step();
    data_data_ok_i = 1'b0; exception_i = 1'b1; data_rdata_i = 32'h0;
    @(negedge clock_i);
    check("exdone_load", load_data_o, 32'hFFFF_FFFE);
    check("exdone_req",  32'(data_req_o), 32'd0);
    step();
    do_access(OP_SH, 32'h0000_0060, 32'h0000_BEEF, 32'h0, 0, 1, 0);

    // Reset mid-transaction
    mem_aluop_i = OP_LW; mem_addr_i = 32'h0000_0040; exception_i = 1'b0; pipe_hold_i = 1'b0;
    @(negedge clock_i);
    step();
    reset_i = 1'b1;
    @(negedge clock_i);
    check("midrst_req",   32'(data_req_o),   32'd0);
    check("midrst_stall", 32'(data_stall_o), 32'd0);
    step();
    reset_i = 1'b0;
    do_access(OP_SW, 32'h0000_0080, 32'h0BAD_CAFE, 32'h0, 0, 1, 0);

    // Randomized accesses
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = m_issued_addr(op, a);
      do_access(op, a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) idle_cycle("ridle");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
